// File: rtl/led_show_pkg.sv
// Shared definitions for the LED light-show sequencer.
//   - phase_e      : phase codes as seen on the phase output
//   - *_DEF        : default tick exponent base and step counts
//   - FINALE_POS   : LED positions lit on the even FINALE steps
//   - led_pattern(): LED image for a given phase and step
package led_show_pkg;

    localparam int unsigned CNT_W            = 11;
    localparam int unsigned DIV_BASE_DEF     = 4;
    localparam int unsigned BAR_STEPS        = 8;
    localparam int unsigned BLINK_STEPS_DEF  = 20;
    localparam int unsigned NIBBLE_STEPS_DEF = 16;
    localparam int unsigned FINALE_STEPS     = 10;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FILL   = 3'd1,
        PH_DRAIN  = 3'd2,
        PH_WALK_R = 3'd3,
        PH_WALK_L = 3'd4,
        PH_BLINK  = 3'd5,
        PH_NIBBLE = 3'd6,
        PH_FINALE = 3'd7
    } phase_e;

    // Entry 0 is used on step 0, entry 1 on step 2, and so on.
    localparam logic [4:0][2:0] FINALE_POS = {3'd5, 3'd3, 3'd0, 3'd6, 3'd2};

    function automatic logic [7:0] led_pattern(input phase_e ph, input logic [7:0] s);
        logic [7:0] half;
        logic [2:0] pos;
        half = s >> 1;
        pos  = (half < 8'd5) ? FINALE_POS[half[2:0]] : 3'd0;
        case (ph)
            PH_FILL:   led_pattern = 8'hFF << (8'd7 - s);
            PH_DRAIN:  led_pattern = 8'hFF << (s + 8'd1);
            PH_WALK_R: led_pattern = 8'h80 >> s;
            PH_WALK_L: led_pattern = 8'h01 << s;
            PH_BLINK:  led_pattern = s[0] ? 8'h00 : 8'hFF;
            PH_NIBBLE: led_pattern = s[0] ? 8'hF0 : 8'h0F;
            PH_FINALE: led_pattern = s[0] ? 8'h00 : (8'h80 >> pos);
            default:   led_pattern = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/led_show_sequencer_if.sv
// Override requester link to the LED bus.
//   ovr_req : requester wants the LED bus
//   ovr_led : pattern to drive while granted
//   ovr_gnt : registered grant back to the requester
// master = requester side, slave = sequencer side.
interface led_show_sequencer_if;
    logic       ovr_req;
    logic [7:0] ovr_led;
    logic       ovr_gnt;

    modport master (output ovr_req, output ovr_led, input ovr_gnt);
    modport slave  (input ovr_req, input ovr_led, output ovr_gnt);
endinterface

// File: rtl/led_tick_gen.sv
// Tick prescaler for the light show.
//   clk, rst_n : clock, async active-low reset
//   speed_i    : rate select, tick period = 2^(DIV_BASE+speed_i) clk cycles
//   tick_o     : one-clk strobe while the low DIV_BASE+speed_i counter bits are all ones
module led_tick_gen
    import led_show_pkg::*;
#(
    parameter int unsigned DIV_BASE = DIV_BASE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] speed_i,
    output logic       tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mask;
    logic             tick_q, tick_d;

    // The strobe is decoded from the incoming count so that the registered
    // tick is high in exactly the cycle the counter holds the all-ones value.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        mask  = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            if (i < DIV_BASE + {29'd0, speed_i}) begin
                mask[i] = 1'b1;
            end
        end
        tick_d = ((cnt_d & mask) == mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/led_show_sequencer.sv
// LED light-show sequencer: FILL, DRAIN, WALK_R, WALK_L, BLINK, NIBBLE, FINALE.
//   clk, rst_n : clock, async active-low reset
//   speed      : tick rate select (0 = fastest)
//   run        : 1 = show enabled and looping, 0 = back to IDLE on next tick
//   hold       : freeze the current step (ticks dropped)
//   skip       : on tick, jump to the next phase, step 0
//   ovr        : override requester link (slave side); grant pauses the show
//   led        : registered LED drive
//   phase      : current phase code
//   done       : one-clk pulse when FINALE completes
module led_show_sequencer
    import led_show_pkg::*;
#(
    parameter int unsigned DIV_BASE     = DIV_BASE_DEF,
    parameter int unsigned BLINK_STEPS  = BLINK_STEPS_DEF,
    parameter int unsigned NIBBLE_STEPS = NIBBLE_STEPS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  speed,
    input  logic                        run,
    input  logic                        hold,
    input  logic                        skip,
    led_show_sequencer_if.slave         ovr,
    output logic [7:0]                  led,
    output logic [2:0]                  phase,
    output logic                        done
);

    logic       tick;
    logic       adv;
    phase_e     phase_q;
    phase_e     phase_adv;
    logic [7:0] step_q;
    logic [7:0] step_last;
    logic [7:0] led_q;
    logic       done_q;
    logic       ovr_gnt_q;

    led_tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .speed_i (speed),
        .tick_o  (tick)
    );

    // Ticks during hold or grant are simply lost.
    assign adv = tick & ~hold & ~ovr_gnt_q;

    always_comb begin
        step_last = '0;
        phase_adv = PH_FILL;
        case (phase_q)
            PH_FILL:   begin step_last = 8'(BAR_STEPS - 1);    phase_adv = PH_DRAIN;  end
            PH_DRAIN:  begin step_last = 8'(BAR_STEPS - 1);    phase_adv = PH_WALK_R; end
            PH_WALK_R: begin step_last = 8'(BAR_STEPS - 1);    phase_adv = PH_WALK_L; end
            PH_WALK_L: begin step_last = 8'(BAR_STEPS - 1);    phase_adv = PH_BLINK;  end
            PH_BLINK:  begin step_last = 8'(BLINK_STEPS - 1);  phase_adv = PH_NIBBLE; end
            PH_NIBBLE: begin step_last = 8'(NIBBLE_STEPS - 1); phase_adv = PH_FINALE; end
            PH_FINALE: begin step_last = 8'(FINALE_STEPS - 1); phase_adv = PH_FILL;   end
            default:   begin step_last = '0;                   phase_adv = PH_FILL;   end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_IDLE;
            step_q    <= '0;
            led_q     <= '0;
            done_q    <= 1'b0;
            ovr_gnt_q <= 1'b0;
        end else begin
            ovr_gnt_q <= ovr.ovr_req;
            // LED image lags the state by one clk; the override wins outright.
            led_q     <= ovr_gnt_q ? ovr.ovr_led : led_pattern(phase_q, step_q);
            done_q    <= 1'b0;
            if (adv) begin
                if (!run) begin
                    phase_q <= PH_IDLE;
                    step_q  <= '0;
                end else if (phase_q == PH_IDLE) begin
                    phase_q <= PH_FILL;
                    step_q  <= '0;
                end else if (skip || step_q == step_last) begin
                    phase_q <= phase_adv;
                    step_q  <= '0;
                    if (phase_q == PH_FINALE) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    step_q <= step_q + 8'd1;
                end
            end
        end
    end

    assign ovr.ovr_gnt = ovr_gnt_q;
    assign led         = led_q;
    assign phase       = phase_q;
    assign done        = done_q;

endmodule
